btb_predict_update: RTL and testbench

Direct-mapped branch target buffer holding per-entry tag, target and 2-bit direction state.
- **IF side:** a combinational lookup produces the next-PC prediction.
- **EX side:** branch resolution detects mispredicts, redirects fetch, and writes the next predictor state back into the table.

It sits between the fetch PC mux and the execute stage of the 5-stage pipeline. It is the table owner and driver of the 2-bit predictor update path.

---
 rtl/btb_predict_update_pkg.sv | 17 +
 rtl/btb_state_fsm.sv | 22 ++
 rtl/btb_predict_update.sv | 139 +++++++++++++
 tb/tb_btb_predict_update.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_predict_update_pkg.sv
// rtl/btb_predict_update_pkg.sv - shared BTB state encodings and default table size
package btb_predict_update_pkg;

  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } btb_state_e;

  localparam int BTB_DEFAULT_ENTRIES = 64;

  function automatic logic predicts_taken(input btb_state_e s);
    return s[1];
  endfunction

endpackage

// File: rtl/btb_state_fsm.sv
// rtl/btb_state_fsm.sv - combinational 2-bit direction state transition function
module btb_state_fsm
  import btb_predict_update_pkg::*;
(
  input  btb_state_e cur_state_i,
  input  logic       mispredicted_i,
  output btb_state_e next_state_o
);

  // A weak state that mispredicts jumps straight to the opposite strong state.
  always_comb begin
    next_state_o = cur_state_i;
    case (cur_state_i)
      STRONG_NOT_TAKEN: next_state_o = mispredicted_i ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   next_state_o = mispredicted_i ? STRONG_TAKEN   : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       next_state_o = mispredicted_i ? STRONG_NOT_TAKEN : STRONG_TAKEN;
      STRONG_TAKEN:     next_state_o = mispredicted_i ? WEAK_TAKEN     : STRONG_TAKEN;
      default:          next_state_o = STRONG_NOT_TAKEN;
    endcase
  end

endmodule

// File: rtl/btb_predict_update.sv
// rtl/btb_predict_update.sv - direct-mapped BTB: IF lookup, EX mispredict/redirect, table update
// Optional statistics counters are built when BTB_STATS_EN is defined.
module btb_predict_update
  import btb_predict_update_pkg::*;
#(
  parameter  int ENTRIES    = BTB_DEFAULT_ENTRIES,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        if_predict_taken,
  output logic [31:0] if_predict_target,
  input  logic        ex_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_flush,
  output logic [31:0] ex_redirect_pc
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  btb_state_e            state_q  [ENTRIES];

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic                  if_hit;
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  ex_hit;
  btb_state_e            ex_cur_state;
  btb_state_e            ex_next_state;
  logic                  ex_dir_mispredicted;
  logic [31:0]           ex_seq_pc;
  logic                  unused_if_pc_bits;

  assign unused_if_pc_bits = ^if_pc[1:0];

  // IF-side lookup reads the table as registered; there is no EX bypass.
  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  always_comb begin
    if_predict_taken  = 1'b0;
    if_predict_target = 32'h0;
    if (!rst && if_hit && predicts_taken(state_q[if_idx])) begin
      if_predict_taken  = 1'b1;
      if_predict_target = target_q[if_idx];
    end
  end

  assign ex_seq_pc = ex_pc + 32'd4;

  always_comb begin
    ex_flush       = 1'b0;
    ex_redirect_pc = ex_seq_pc;
    if (!rst && ex_branch &&
        ((ex_pred_taken != ex_taken) || (ex_taken && (ex_pred_target != ex_target)))) begin
      ex_flush       = 1'b1;
      ex_redirect_pc = ex_taken ? ex_target : ex_seq_pc;
    end
  end

  assign ex_idx              = ex_pc[INDEX_BITS+1:2];
  assign ex_tag              = ex_pc[31:INDEX_BITS+2];
  assign ex_hit              = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_cur_state        = state_q[ex_idx];
  assign ex_dir_mispredicted = predicts_taken(ex_cur_state) != ex_taken;

  btb_state_fsm u_state_fsm (
    .cur_state_i    (ex_cur_state),
    .mispredicted_i (ex_dir_mispredicted),
    .next_state_o   (ex_next_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        state_q[i] <= STRONG_NOT_TAKEN;
      end
    end else if (ex_branch) begin
      if (ex_hit) begin
        state_q[ex_idx] <= ex_next_state;
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        state_q[ex_idx] <= WEAK_TAKEN;
      end
    end
  end

  // Tags and targets carry no reset; they are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && ex_branch && ex_taken) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (ex_branch && (stat_branches_q != 32'hFFFF_FFFF))
      stat_branches_d = stat_branches_q + 32'd1;
    if (ex_flush && (stat_mispredicts_q != 32'hFFFF_FFFF))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= 32'h0;
      stat_mispredicts_q <= 32'h0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = rst ? 32'h0 : stat_branches_q;
  assign stat_mispredicts = rst ? 32'h0 : stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_btb_predict_update.sv
// tb/tb_btb_predict_update.sv - directed bench with per-cycle reference model for btb_predict_update
module tb_btb_predict_update;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_predict_taken;
  logic [31:0] if_predict_target;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_flush;
  logic [31:0] ex_redirect_pc;
`ifdef BTB_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;
  bit model_live = 0;

  always #5 clk = ~clk;

  btb_predict_update #(.ENTRIES(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_pc             (if_pc),
    .if_predict_taken  (if_predict_taken),
    .if_predict_target (if_predict_target),
    .ex_branch         (ex_branch),
    .ex_pc             (ex_pc),
    .ex_taken          (ex_taken),
    .ex_target         (ex_target),
    .ex_pred_taken     (ex_pred_taken),
    .ex_pred_target    (ex_pred_target),
    .ex_flush          (ex_flush),
    .ex_redirect_pc    (ex_redirect_pc)
`ifdef BTB_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  // Reference table: state is 0..3 with 0 = strong not-taken, 3 = strong taken.
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  int          m_state  [64];
  longint      m_branches, m_mispredicts;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / 256;
  endfunction

  function automatic int next_state(input int s, input bit taken);
    bit wrong = (s >= 2) != taken;
    if (!wrong) return (s >= 2) ? 3 : 0;
    case (s)
      0: return 1;
      1: return 3;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  function automatic bit m_flush();
    if (rst || !ex_branch) return 0;
    return (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 0;
        m_state[i] = 0;
      end
      m_branches   = 0;
      m_mispredicts = 0;
    end else if (ex_branch) begin
      if (m_flush() && m_mispredicts < 64'hFFFF_FFFF) m_mispredicts++;
      if (m_branches < 64'hFFFF_FFFF) m_branches++;
      if (m_hit(ex_pc)) begin
        m_state[idx_of(ex_pc)] = next_state(m_state[idx_of(ex_pc)], ex_taken);
        if (ex_taken) m_target[idx_of(ex_pc)] = ex_target;
      end else if (ex_taken) begin
        m_valid[idx_of(ex_pc)]  = 1;
        m_tag[idx_of(ex_pc)]    = tag_of(ex_pc);
        m_target[idx_of(ex_pc)] = ex_target;
        m_state[idx_of(ex_pc)]  = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      bit          e_taken;
      logic [31:0] e_tgt;
      logic [31:0] e_redir;
      e_taken = !rst && m_hit(if_pc) && m_state[idx_of(if_pc)] >= 2;
      e_tgt   = e_taken ? m_target[idx_of(if_pc)] : 32'h0;
      e_redir = (m_flush() && ex_taken) ? ex_target : ex_pc + 32'd4;
      checks++;
      if (if_predict_taken !== e_taken || if_predict_target !== e_tgt) begin
        errors++;
        $display("FAIL model_lookup pc=%h got taken=%b tgt=%h want taken=%b tgt=%h",
                 if_pc, if_predict_taken, if_predict_target, e_taken, e_tgt);
      end
      checks++;
      if (ex_flush !== m_flush() || ex_redirect_pc !== e_redir) begin
        errors++;
        $display("FAIL model_resolve pc=%h got flush=%b redir=%h want flush=%b redir=%h",
                 ex_pc, ex_flush, ex_redirect_pc, m_flush(), e_redir);
      end
`ifdef BTB_STATS_EN
      checks++;
      if (stat_branches !== (rst ? 32'h0 : 32'(m_branches)) ||
          stat_mispredicts !== (rst ? 32'h0 : 32'(m_mispredicts))) begin
        errors++;
        $display("FAIL model_stats got br=%0d mis=%0d want br=%0d mis=%0d",
                 stat_branches, stat_mispredicts, m_branches, m_mispredicts);
      end
`endif
    end
  end

  task automatic set_ex(input bit br, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    ex_branch = br; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic idle_ex();
    set_ex(0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Hand-computed literal expectation at the negedge of the current cycle, then advance.
  task automatic expect_cycle(input string name, input bit e_ptk, input logic [31:0] e_ptgt,
                              input bit e_fl, input logic [31:0] e_redir);
    @(negedge clk);
    checks++;
    if (if_predict_taken !== e_ptk || if_predict_target !== e_ptgt ||
        ex_flush !== e_fl || ex_redirect_pc !== e_redir) begin
      errors++;
      $display("FAIL %s got ptk=%b ptgt=%h flush=%b redir=%h want ptk=%b ptgt=%h flush=%b redir=%h",
               name, if_predict_taken, if_predict_target, ex_flush, ex_redirect_pc,
               e_ptk, e_ptgt, e_fl, e_redir);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; if_pc = 32'h100; idle_ex();
    @(posedge clk); #1;
    model_live = 1;
    expect_cycle("reset_lookup", 0, 32'h0, 0, 32'h4);
`ifdef BTB_STATS_EN
    checks++;
    if (stat_branches !== 0 || stat_mispredicts !== 0) begin
      errors++;
      $display("FAIL reset_stats got br=%0d mis=%0d want 0 0", stat_branches, stat_mispredicts);
    end
`endif
    rst = 0;
    expect_cycle("miss_after_reset", 0, 32'h0, 0, 32'h4);

    set_ex(1, 32'h100, 1, 32'h200, 0, 32'h0);
    expect_cycle("allocate", 0, 32'h0, 1, 32'h200);
    idle_ex();
    expect_cycle("alloc_lookup", 1, 32'h200, 0, 32'h4);

    set_ex(1, 32'h100, 1, 32'h200, 1, 32'h200);
    expect_cycle("strengthen", 1, 32'h200, 0, 32'h104);
    set_ex(1, 32'h100, 0, 32'h0, 1, 32'h200);
    expect_cycle("demote_flush", 1, 32'h200, 1, 32'h104);
    idle_ex();
    expect_cycle("still_taken_wt", 1, 32'h200, 0, 32'h4);
    set_ex(1, 32'h100, 0, 32'h0, 1, 32'h200);
    expect_cycle("demote_again", 1, 32'h200, 1, 32'h104);
    idle_ex();
    expect_cycle("now_not_taken", 0, 32'h0, 0, 32'h4);

    // SNT -> WNT -> ST via two taken resolutions, then retarget.
    set_ex(1, 32'h100, 1, 32'h200, 0, 32'h0);
    expect_cycle("snt_to_wnt", 0, 32'h0, 1, 32'h200);
    expect_cycle("wnt_to_st", 0, 32'h0, 1, 32'h200);
    idle_ex();
    expect_cycle("st_lookup", 1, 32'h200, 0, 32'h4);
    set_ex(1, 32'h100, 1, 32'h300, 1, 32'h200);
    expect_cycle("target_change", 1, 32'h200, 1, 32'h300);
    idle_ex();
    expect_cycle("new_target", 1, 32'h300, 0, 32'h4);

    set_ex(1, 32'h200, 1, 32'h500, 0, 32'h0);
    expect_cycle("alias_alloc", 1, 32'h300, 1, 32'h500);
    idle_ex();
    expect_cycle("alias_old_miss", 0, 32'h0, 0, 32'h4);
    if_pc = 32'h200;
    expect_cycle("alias_new_hit", 1, 32'h500, 0, 32'h4);

    if_pc = 32'h40;
    set_ex(1, 32'h40, 1, 32'h80, 0, 32'h0);
    expect_cycle("same_cycle_old", 0, 32'h0, 1, 32'h80);
    idle_ex();
    expect_cycle("same_cycle_new", 1, 32'h80, 0, 32'h4);

    rst = 1; if_pc = 32'h300;
    set_ex(1, 32'h300, 1, 32'h400, 0, 32'h0);
    expect_cycle("reset_collision", 0, 32'h0, 0, 32'h304);
    rst = 0; idle_ex();
    expect_cycle("no_alloc_on_reset", 0, 32'h0, 0, 32'h4);
    if_pc = 32'h40;
    expect_cycle("reset_cleared", 0, 32'h0, 0, 32'h4);

    if_pc = 32'h500;
    set_ex(1, 32'h500, 0, 32'h0, 0, 32'h0);
    expect_cycle("nt_miss", 0, 32'h0, 0, 32'h504);
    idle_ex();
    expect_cycle("nt_no_alloc", 0, 32'h0, 0, 32'h4);

    set_ex(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h1234);
    expect_cycle("wrap_redirect", 0, 32'h0, 1, 32'h0);
    idle_ex();
    expect_cycle("idle_tail", 0, 32'h0, 0, 32'h4);

    model_live = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
